// File: rtl/pc_fetch_sequencer.sv
// Instruction-fetch sequencer: program counter, IF/ID register, stall/redirect handling.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned redirect targets to TRAP_VECTOR.
module pc_fetch_sequencer #(
  parameter int              w           = 32,
  parameter logic [w-1:0]    RESET_PC    = '0,
  parameter logic [w-1:0]    TRAP_VECTOR = 32'h0000_0080
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         pcsrc,
  input  logic [w-1:0] branch_target,
  input  logic         jump,
  input  logic [w-1:0] jump_target,
  input  logic [31:0]  instr_in,
  output logic [w-1:0] pc,
  output logic [w-1:0] pc_plus4,
  output logic [31:0]  if_id_instr,
  output logic [w-1:0] if_id_pc4,
  output logic         if_id_valid,
  output logic         misalign
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state, state_next;
  logic [w-1:0] pending, pending_next;
  logic [w-1:0] pc_next, if_id_pc4_next;
  logic [31:0]  if_id_instr_next;
  logic         if_id_valid_next, misalign_next;

  logic         redirect;
  logic [w-1:0] target;
  logic [w-1:0] run_load, hold_load;
  logic         run_trap, hold_trap;

  assign pc_plus4 = pc + w'(4);
  assign redirect = jump | pcsrc;
  assign target   = jump ? jump_target : branch_target;

  // Address actually loaded into pc when a redirect is applied, now or on HOLD exit.
`ifdef MISALIGN_TRAP_EN
  assign run_trap  = |target[1:0];
  assign hold_trap = |pending[1:0];
  assign run_load  = run_trap  ? TRAP_VECTOR : target;
  assign hold_load = hold_trap ? TRAP_VECTOR : pending;
`else
  localparam logic [w-1:0] ALIGN_MASK = {{(w-2){1'b1}}, 2'b00};
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
  assign run_trap  = 1'b0;
  assign hold_trap = 1'b0;
  assign run_load  = target  & ALIGN_MASK;
  assign hold_load = pending & ALIGN_MASK;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next       = state;
    pc_next          = pc;
    pending_next     = pending;
    if_id_instr_next = if_id_instr;
    if_id_pc4_next   = if_id_pc4;
    if_id_valid_next = if_id_valid;
    misalign_next    = 1'b0;

    unique case (state)
      BOOT: begin
        if_id_valid_next = 1'b0;
        state_next       = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (redirect) begin
            pc_next          = run_load;
            misalign_next    = run_trap;
            if_id_instr_next = '0;
            if_id_pc4_next   = '0;
            if_id_valid_next = 1'b0;
          end else begin
            pc_next          = pc_plus4;
            if_id_instr_next = instr_in;
            if_id_pc4_next   = pc_plus4;
            if_id_valid_next = 1'b1;
          end
        end else if (redirect) begin
          pending_next     = target;
          if_id_valid_next = 1'b0;
          state_next       = HOLD;
        end
      end
      HOLD: begin
        // First redirect already latched; later redirects are deliberately dropped.
        if (!stall) begin
          pc_next          = hold_load;
          misalign_next    = hold_trap;
          if_id_instr_next = '0;
          if_id_pc4_next   = '0;
          if_id_valid_next = 1'b0;
          state_next       = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pending     <= '0;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pending     <= pending_next;
      if_id_instr <= if_id_instr_next;
      if_id_pc4   <= if_id_pc4_next;
      if_id_valid <= if_id_valid_next;
      misalign    <= misalign_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed fetch/redirect/stall scenarios,
// then randomized stimulus against a cycle-level behavioural model.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] instr_in = '0;
  logic [31:0] pc, pc_plus4, if_id_instr, if_id_pc4;
  logic        if_id_valid, misalign;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .pcsrc(pcsrc),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .instr_in(instr_in), .pc(pc), .pc_plus4(pc_plus4),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Reference model: what the fetch stage should look like after each edge.
  logic [31:0] m_pc = 0, m_instr = 0, m_pc4 = 0;
  logic        m_valid = 0, m_mis = 0;
  bit          m_booting = 1;
  bit          m_waiting = 0;      // a redirect arrived under stall and is still owed
  logic [31:0] m_owed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_take(input logic [31:0] t);
    m_instr = 0; m_pc4 = 0; m_valid = 0;
`ifdef MISALIGN_TRAP_EN
    if (t % 4 != 0) begin m_pc = 32'h80; m_mis = 1; end
    else begin m_pc = t; m_mis = 0; end
`else
    m_pc = t - (t % 4);
    m_mis = 0;
`endif
  endtask

  task automatic model_step();
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
      m_booting = 1; m_waiting = 0; m_owed = 0;
    end else if (m_booting) begin
      m_booting = 0; m_valid = 0; m_mis = 0;
    end else if (m_waiting) begin
      m_mis = 0;
      if (!stall) begin model_take(m_owed); m_waiting = 0; end
    end else begin
      m_mis = 0;
      if (!stall && (jump || pcsrc)) model_take(jump ? jump_target : branch_target);
      else if (!stall) begin
        m_instr = instr_in; m_pc = m_pc + 4; m_pc4 = m_pc; m_valid = 1;
      end else if (jump || pcsrc) begin
        m_owed = jump ? jump_target : branch_target;
        m_waiting = 1; m_valid = 0;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit ps, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input logic [31:0] ins);
    rst = r; stall = s; pcsrc = ps; branch_target = bt;
    jump = j; jump_target = jt; instr_in = ins;
    model_step();
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc4", if_id_pc4, m_pc4);
    check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    check("misalign", {31'd0, misalign}, {31'd0, m_mis});
  endtask

  localparam logic [31:0] ADDI = 32'h2008_0005;

  initial begin
    logic [31:0] bt, jt;
    @(posedge clk); #1;

    // Reset and boot
    cycle(1, 0, 0, 0, 0, 0, ADDI);
    cycle(1, 0, 0, 0, 0, 0, ADDI);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0, ADDI);
    check("boot_pc", pc, 32'h0);
    cycle(0, 0, 0, 0, 0, 0, ADDI);
    check("first_pc", pc, 32'h4);
    check("first_valid", {31'd0, if_id_valid}, 32'd1);
    check("first_pc4", if_id_pc4, 32'h4);
    check("first_instr", if_id_instr, ADDI);
    cycle(0, 0, 0, 0, 0, 0, ADDI);
    check("seq_pc", pc, 32'h8);

    // Taken branch
    cycle(0, 0, 1, 32'h40, 0, 0, ADDI);
    check("br_pc", pc, 32'h40);
    check("br_bubble", {31'd0, if_id_valid}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0, ADDI);
    check("br_pc4", if_id_pc4, 32'h44);

    // Jump beats branch
    cycle(0, 0, 1, 32'h40, 1, 32'h100, ADDI);
    check("jump_wins", pc, 32'h100);
    cycle(0, 0, 0, 0, 0, 0, ADDI);

    // Redirects under a three-cycle stall: first one wins
    cycle(0, 1, 0, 0, 1, 32'h200, ADDI);
    check("stall1_pc", pc, 32'h104);
    check("stall1_valid", {31'd0, if_id_valid}, 32'd0);
    cycle(0, 1, 1, 32'h300, 0, 0, ADDI);
    check("stall2_pc", pc, 32'h104);
    cycle(0, 1, 0, 0, 0, 0, ADDI);
    check("stall3_valid", {31'd0, if_id_valid}, 32'd0);
    cycle(0, 0, 1, 32'h500, 0, 0, ADDI);
    check("hold_exit_pc", pc, 32'h200);

    // Wrap-around
    cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC, ADDI);
    check("wrap_plus4", pc_plus4, 32'h0);
    cycle(0, 0, 0, 0, 0, 0, ADDI);
    check("wrap_pc", pc, 32'h0);
    check("wrap_pc4", if_id_pc4, 32'h0);

    // Misaligned jump
    cycle(0, 0, 0, 0, 1, 32'h102, ADDI);
`ifdef MISALIGN_TRAP_EN
    check("mis_pc", pc, 32'h80);
    check("mis_pulse", {31'd0, misalign}, 32'd1);
`else
    check("mis_pc", pc, 32'h100);
    check("mis_pulse", {31'd0, misalign}, 32'd0);
`endif
    cycle(0, 0, 0, 0, 0, 0, ADDI);
    check("mis_clear", {31'd0, misalign}, 32'd0);

    // Reset while a redirect is pending
    cycle(0, 1, 0, 0, 1, 32'h700, ADDI);
    cycle(1, 1, 0, 0, 0, 0, ADDI);
    check("midrst_pc", pc, 32'h0);
    cycle(0, 0, 0, 0, 0, 0, ADDI);
    check("midrst_boot", pc, 32'h0);
    cycle(0, 0, 0, 0, 0, 0, ADDI);
    check("midrst_run", pc, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bt = $urandom; jt = $urandom;
      if ($urandom_range(1, 0) == 1) bt[1:0] = 2'b00;
      if ($urandom_range(1, 0) == 1) jt[1:0] = 2'b00;
      cycle($urandom_range(39, 0) == 0, $urandom_range(2, 0) == 0,
            $urandom_range(5, 0) == 0, bt,
            $urandom_range(7, 0) == 0, jt, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Instruction-fetch sequencer for the single-clock MIPS core: holds the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register. It consumes the branch-taken bit produced by the 2-input branch AND gate (`Branch & Zero`) together with the jump controls. It also handles stalls, redirects that arrive during a stall, and wrong-path flushes.

## Interface
- `w`, 32, datapath/address width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `TRAP_VECTOR`, 32'h0000_0080, redirect address for misaligned targets (used only with `MISALIGN_TRAP_EN`).

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit hold request.
- `pcsrc`  in  1  branch taken, from the branch AND gate.
- `branch_target`  in  w  branch target address.
- `jump`  in  1  unconditional jump.
- `jump_target`  in  w  jump target address.
- `instr_in`  in  32  instruction memory read data; combinational from `pc`.
- `pc`  out  w  current fetch address.
- `pc_plus4`  out  w  `pc + 4`, combinational.
- `if_id_instr`  out  32  registered instruction.
- `if_id_pc4`  out  w  registered `pc + 4` of that instruction.
- `if_id_valid`  out  1  IF/ID holds a live instruction.
- `misalign`  out  1  one-cycle pulse when a misaligned target is trapped.

## Operation
- **States:** BOOT, RUN, HOLD. State is encoded in 2 bits.
- **Reset:** `pc`=`RESET_PC`; `if_id_instr`=0; `if_id_pc4`=0; `if_id_valid`=0; `misalign`=0; pending target=0; state BOOT.
- **BOOT:**
  - Lasts exactly one cycle; `pc` held and `if_id_valid`=0.
  - Then → RUN. Inputs are ignored in BOOT.
- **RUN, priority order:**
  - `jump` > `pcsrc` > sequential.
  - Redirect is `jump|pcsrc` with target = `jump ? jump_target : branch_target`.
- **RUN, no stall, no redirect:**
  - `pc <= pc+4`.
  - IF/ID <= {`instr_in`, `pc+4`, valid=1}.
- **RUN, no stall, redirect:**
  - `pc <= target`.
  - IF/ID flushed: instr=0, pc4=0, valid=0.
- **RUN, stall, no redirect:**
  - `pc` and IF/ID hold.
- **RUN, stall, redirect:**
  - Target is latched into the pending register; `pc` holds.
  - `if_id_valid <= 0`; instr and pc4 hold.
  - → HOLD.
- **HOLD, stall=1:**
  - Everything holds.
  - Further `jump`/`pcsrc` are ignored; the first redirect wins.
- **HOLD, stall=0:**
  - `pc <= pending`; IF/ID flushed; → RUN.
  - Redirect inputs in this cycle are ignored.
- **Arithmetic:** `pc+4` is modulo 2^w, so `32'hFFFF_FFFC` wraps to 0.
- **Mid-operation reset:** `rst` in any state, including HOLD with a pending target, discards everything and yields the reset values on the next edge.

## Timing
- Fetch-to-IF/ID latency is 1 cycle: `instr_in` sampled at edge N appears on `if_id_instr` after edge N.
- Redirect penalty is 1 bubble: the target appears on `pc` the cycle after the redirect, and `if_id_valid`=0 for that cycle.
- Redirect during stall: `pc` equals the target one cycle after `stall` falls.
- First valid instruction: `if_id_valid`=1 two cycles after `rst` deasserts (BOOT + one fetch).
- `pc_plus4` is combinational from `pc`. All other outputs are registered.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A redirect whose target has bits [1:0] ≠ 0 loads `pc <= TRAP_VECTOR` instead of the target.
  - `misalign` pulses high for exactly the cycle in which `pc` equals `TRAP_VECTOR` as a result.
  - This applies at both application points: the immediate RUN redirect and HOLD exit.
- `MISALIGN_TRAP_EN` undefined:
  - Target bits [1:0] are forced to 00 on load.
  - `misalign` is tied to 0.
  - `TRAP_VECTOR` is unused.

## Test plan
- Reset then free-run with `instr_in`=`32'h2008_0005`:
  - `pc`: 0, 0 (BOOT), 4, 8.
  - `if_id_valid` rises in the third cycle with `if_id_pc4`=4.
- At `pc`=8, `pcsrc`=1 with `branch_target`=`32'h40`:
  - Next cycle `pc`=`32'h40` and `if_id_valid`=0.
  - The following cycle `if_id_pc4`=`32'h44`.
- Same cycle `jump`=1 to `32'h100` and `pcsrc`=1 to `32'h40`:
  - `pc`=`32'h100` (jump wins).
- `stall`=1 for 3 cycles:
  - Redirect to `32'h200` in cycle 1, redirect to `32'h300` in cycle 2.
  - `pc` holds throughout; `if_id_valid`=0 from cycle 2.
  - After `stall` drops, `pc`=`32'h200`.
- Wrap: force `pc` to `32'hFFFF_FFFC` via jump, then run:
  - Next `pc`=0 and `if_id_pc4`=0.
- With `MISALIGN_TRAP_EN`, jump to `32'h102`:
  - `pc`=`32'h80` with `misalign`=1 for one cycle.
- Without the macro, the same jump gives `pc`=`32'h100` and `misalign`=0.
